// File: rtl/clk_div_sched.sv
// rtl/clk_div_sched.sv - round-robin arbitrated programmable clock divider
// One requester at a time owns clk_out for a fixed number of output periods.
module clk_div_sched #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int CW   = 16
) (
  input  logic                 clk_in,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*W-1:0]    div_n,
  input  logic [NREQ*CW-1:0]   cycles,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 clk_out,
  output logic                 tick,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      err
);
  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   sel_q, sel_d, ptr_q, ptr_d;
  logic [W-1:0]    h_q, h_d, cnt_q, cnt_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic            busy_q, busy_d, clk_out_q, clk_out_d, tick_q, tick_d;

  logic            scan_hit;
  logic [PW-1:0]   scan_sel, scan_idx, scan_nxt, sel_nxt;
  logic [W-1:0]    scan_div;
  logic [CW-1:0]   scan_cyc;
  logic [NREQ-1:0] scan_oh, sel_oh;
  logic            abort;

  // Rotating priority scan starting at ptr; first requester found wins.
  always_comb begin
    scan_hit = 1'b0;
    scan_sel = '0;
    scan_idx = '0;
    scan_div = '0;
    scan_cyc = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = PW'((int'(ptr_q) + k) % NREQ);
      if (!scan_hit && req[scan_idx]) begin
        scan_hit = 1'b1;
        scan_sel = scan_idx;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (scan_sel == PW'(k)) begin
        scan_div = div_n[k*W +: W];
        scan_cyc = cycles[k*CW +: CW];
      end
    end
  end

  assign scan_oh  = {{(NREQ-1){1'b0}}, 1'b1} << scan_sel;
  assign sel_oh   = {{(NREQ-1){1'b0}}, 1'b1} << sel_q;
  assign scan_nxt = (int'(scan_sel) == NREQ-1) ? '0 : scan_sel + 1'b1;
  assign sel_nxt  = (int'(sel_q) == NREQ-1) ? '0 : sel_q + 1'b1;
  assign abort    = !req[sel_q];

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    h_d       = h_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    done_d    = '0;
    err_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (scan_hit) begin
          if (scan_div < W'(2) || scan_cyc == '0) begin
            err_d = scan_oh;
            ptr_d = scan_nxt;
          end else begin
            state_d   = S_LOAD;
            sel_d     = scan_sel;
            h_d       = scan_div >> 1;
            rem_d     = scan_cyc;
            cnt_d     = '0;
            gnt_d     = scan_oh;
            busy_d    = 1'b1;
            clk_out_d = 1'b1;
          end
        end
      end
      S_LOAD, S_RUN: begin
        // A dropped request releases the engine and wins over any toggle.
        if (abort) begin
          state_d   = S_IDLE;
          gnt_d     = '0;
          busy_d    = 1'b0;
          clk_out_d = 1'b1;
          cnt_d     = '0;
          ptr_d     = sel_nxt;
        end else if (state_q == S_LOAD) begin
          state_d = S_RUN;
        end else if (cnt_q == h_q - 1'b1) begin
          cnt_d     = '0;
          clk_out_d = ~clk_out_q;
          if (!clk_out_q) begin
            tick_d = 1'b1;
            rem_d  = rem_q - 1'b1;
            if (rem_q == CW'(1)) begin
              state_d = S_DONE;
              done_d  = sel_oh;
              gnt_d   = '0;
              busy_d  = 1'b0;
              ptr_d   = sel_nxt;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        clk_out_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      ptr_q     <= '0;
      h_q       <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      clk_out_q <= 1'b1;
      tick_q    <= 1'b0;
      done_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      h_q       <= h_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
